// File: rtl/operand_fetch_seq_if.sv
// Memory read port between the operand fetch sequencer and the memory system.
// The master drives address/request and the slave returns data/ready.
interface operand_fetch_seq_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] mab;
    logic              mem_rd;
    logic [DATA_W-1:0] mdb;
    logic              mem_rdy;

    modport master (output mab, output mem_rd, input mdb, input mem_rdy);
    modport slave  (input mab, input mem_rd, output mdb, output mem_rdy);
endinterface

// File: rtl/operand_fetch_seq.sv
// Multi-cycle MSP430/MSP430X operand fetch: reads extension words and memory
// operands over a ready-handshaked port and returns operands, dst address and PC.
module operand_fetch_seq #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [1:0]          i_src_mode,
    input  logic                i_dst_mode,
    input  logic                i_dst_rd,
    input  logic                i_bw,
    input  logic                i_src_is_pc,
    input  logic [ADDR_W-1:0]   i_r_src,
    input  logic [ADDR_W-1:0]   i_r_dst,
    input  logic [ADDR_W-1:0]   i_pc,
    operand_fetch_seq_if.master bus,
    output logic [DATA_W-1:0]   o_op_src,
    output logic [DATA_W-1:0]   o_op_dst,
    output logic [ADDR_W-1:0]   o_dst_addr,
    output logic [ADDR_W-1:0]   o_pc_out,
    output logic [1:0]          o_src_inc,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [2:0] {
        StIdle, StSrcExt, StSrcRd, StDstExt, StDstRd, StDone
    } state_e;

    state_e            r_state, w_state_d;
    logic [1:0]        r_src_mode;
    logic              r_dst_mode, r_dst_rd, r_bw, r_src_is_pc;
    logic [ADDR_W-1:0] r_rsrc, r_rdst, r_pc_cur, r_ea, r_dst_addr;
    logic [DATA_W-1:0] r_op_src, r_op_dst;
    logic [1:0]        r_src_inc;

    logic [ADDR_W-1:0] w_addr, w_mab, w_mdb_addr, w_base;
    logic              w_mem_rd, w_word, w_imm;
    logic [7:0]        w_lane;
    logic [DATA_W-1:0] w_rd_data, w_reg_src, w_reg_dst;
    logic [1:0]        w_inc;

    // Next state after 'cur', visiting only the stages the addressing modes need.
    function automatic state_e f_next(state_e cur, logic [1:0] sm, logic dm, logic drd,
                                      logic spc);
        logic   need_ext;
        logic   need_rd;
        state_e s;
        need_ext = (sm == 2'd1) || (sm == 2'd3 && spc);
        need_rd  = (sm != 2'd0) && !(sm == 2'd3 && spc);
        s = StDone;
        if (dm && drd && cur < StDstRd) s = StDstRd;
        if (dm && cur < StDstExt) s = StDstExt;
        if (need_rd && cur < StSrcRd) s = StSrcRd;
        if (need_ext && cur == StIdle) s = StSrcExt;
        return s;
    endfunction

    assign w_imm      = (r_src_mode == 2'd3) && r_src_is_pc;
    assign w_mdb_addr = ADDR_W'(bus.mdb);
    assign w_base     = r_src_is_pc ? r_pc_cur : r_rsrc;
    assign w_reg_src  = i_bw ? DATA_W'(i_r_src[7:0]) : DATA_W'(i_r_src);
    assign w_reg_dst  = i_bw ? DATA_W'(i_r_dst[7:0]) : DATA_W'(i_r_dst);
    assign w_inc      = (i_src_mode != 2'd3) ? 2'd0 : ((!i_bw || i_src_is_pc) ? 2'd2 : 2'd1);

    always_comb begin
        w_state_d = r_state;
        w_addr    = '0;
        w_word    = 1'b1;
        w_mem_rd  = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = f_next(StIdle, i_src_mode, i_dst_mode, i_dst_rd, i_src_is_pc);
                end
            end
            StSrcExt, StDstExt: begin
                w_mem_rd = 1'b1;
                w_addr   = r_pc_cur;
            end
            StSrcRd: begin
                w_mem_rd = 1'b1;
                w_word   = !r_bw;
                w_addr   = (r_src_mode == 2'd1) ? r_ea : r_rsrc;
            end
            StDstRd: begin
                w_mem_rd = 1'b1;
                w_word   = !r_bw;
                w_addr   = r_dst_addr;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (w_mem_rd && bus.mem_rdy) begin
            w_state_d = f_next(r_state, r_src_mode, r_dst_mode, r_dst_rd, r_src_is_pc);
        end
    end

    assign w_mab     = w_word ? {w_addr[ADDR_W-1:1], 1'b0} : w_addr;
    assign w_lane    = w_mab[0] ? bus.mdb[15:8] : bus.mdb[7:0];
    assign w_rd_data = r_bw ? DATA_W'(w_lane) : bus.mdb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_src_mode  <= 2'd0;
            r_dst_mode  <= 1'b0;
            r_dst_rd    <= 1'b0;
            r_bw        <= 1'b0;
            r_src_is_pc <= 1'b0;
            r_rsrc      <= '0;
            r_rdst      <= '0;
            r_pc_cur    <= '0;
            r_ea        <= '0;
            r_dst_addr  <= '0;
            r_op_src    <= '0;
            r_op_dst    <= '0;
            r_src_inc   <= 2'd0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_src_mode  <= i_src_mode;
                        r_dst_mode  <= i_dst_mode;
                        r_dst_rd    <= i_dst_rd;
                        r_bw        <= i_bw;
                        r_src_is_pc <= i_src_is_pc;
                        r_rsrc      <= i_r_src;
                        r_rdst      <= i_r_dst;
                        r_pc_cur    <= i_pc;
                        r_ea        <= '0;
                        r_dst_addr  <= '0;
                        r_op_src    <= (i_src_mode == 2'd0) ? w_reg_src : '0;
                        r_op_dst    <= (!i_dst_mode) ? w_reg_dst : '0;
                        r_src_inc   <= w_inc;
                    end
                end
                StSrcExt: begin
                    if (bus.mem_rdy) begin
                        if (w_imm) r_op_src <= bus.mdb;
                        else       r_ea     <= w_base + w_mdb_addr;
                        r_pc_cur <= r_pc_cur + ADDR_W'(2);
                    end
                end
                StSrcRd: begin
                    if (bus.mem_rdy) r_op_src <= w_rd_data;
                end
                StDstExt: begin
                    if (bus.mem_rdy) begin
                        r_dst_addr <= r_rdst + w_mdb_addr;
                        r_pc_cur   <= r_pc_cur + ADDR_W'(2);
                    end
                end
                StDstRd: begin
                    if (bus.mem_rdy) r_op_dst <= w_rd_data;
                end
                default: ;
            endcase
        end
    end

    // PC register doubles as pc_out: it already equals pc_cur when done pulses.
    assign bus.mab    = w_mab;
    assign bus.mem_rd = w_mem_rd;
    assign o_op_src   = r_op_src;
    assign o_op_dst   = r_op_dst;
    assign o_dst_addr = r_dst_addr;
    assign o_pc_out   = r_pc_cur;
    assign o_src_inc  = r_src_inc;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StDone);

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed bench for operand_fetch_seq: a 16-bit and a 20-bit instance share
// stimulus and a word-addressed memory model with programmable wait states.
module tb_operand_fetch_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  src_mode = 2'd0;
    logic        dst_mode = 1'b0, dst_rd = 1'b0, bw = 1'b0, src_is_pc = 1'b0;
    logic [19:0] r_src = '0, r_dst = '0, pc = '0;

    logic [15:0] op_src16, op_dst16, dst_addr16, pc_out16;
    logic [1:0]  src_inc16, src_inc20;
    logic        busy16, done16, busy20, done20;
    logic [15:0] op_src20, op_dst20;
    logic [19:0] dst_addr20, pc_out20;

    int total = 0;
    int bad = 0;
    int wait_n = 0;
    int cnt16 = 0;
    int cnt20 = 0;
    int mem_gen = 0;
    logic [15:0] mem [int];

    operand_fetch_seq_if #(.ADDR_W(16), .DATA_W(16)) bus16 ();
    operand_fetch_seq_if #(.ADDR_W(20), .DATA_W(16)) bus20 ();

    operand_fetch_seq #(.ADDR_W(16), .DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .i_start(start), .i_src_mode(src_mode), .i_dst_mode(dst_mode),
        .i_dst_rd(dst_rd), .i_bw(bw), .i_src_is_pc(src_is_pc), .i_r_src(r_src[15:0]),
        .i_r_dst(r_dst[15:0]), .i_pc(pc[15:0]), .bus(bus16.master), .o_op_src(op_src16),
        .o_op_dst(op_dst16), .o_dst_addr(dst_addr16), .o_pc_out(pc_out16),
        .o_src_inc(src_inc16), .o_busy(busy16), .o_done(done16)
    );

    operand_fetch_seq #(.ADDR_W(20), .DATA_W(16)) dut20 (
        .clk(clk), .rst(rst), .i_start(start), .i_src_mode(src_mode), .i_dst_mode(dst_mode),
        .i_dst_rd(dst_rd), .i_bw(bw), .i_src_is_pc(src_is_pc), .i_r_src(r_src),
        .i_r_dst(r_dst), .i_pc(pc), .bus(bus20.master), .o_op_src(op_src20),
        .o_op_dst(op_dst20), .o_dst_addr(dst_addr20), .o_pc_out(pc_out20),
        .o_src_inc(src_inc20), .o_busy(busy20), .o_done(done20)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd_f(int a);
        if (mem.exists(a >> 1)) return mem[a >> 1];
        return 16'hDEAD;
    endfunction

    task automatic mem_wr(int a, logic [15:0] d);
        mem[a >> 1] = d;
        mem_gen++;
    endtask

    always @(bus16.mab or mem_gen) bus16.mdb = mem_rd_f(int'(bus16.mab));
    always @(bus20.mab or mem_gen) bus20.mdb = mem_rd_f(int'(bus20.mab));
    assign bus16.mem_rdy = bus16.mem_rd && (cnt16 >= wait_n);
    assign bus20.mem_rdy = bus20.mem_rd && (cnt20 >= wait_n);

    // Wait-state counters: count stalled cycles of the current request.
    always @(posedge clk) begin
        if (!bus16.mem_rd || bus16.mem_rdy) cnt16 <= 0; else cnt16 <= cnt16 + 1;
        if (!bus20.mem_rd || bus20.mem_rdy) cnt20 <= 0; else cnt20 <= cnt20 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(output int cyc, output int rd_cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        rd_cnt = 0;
        while (!done16 && cyc < 200) begin
            if (bus16.mem_rd) rd_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        tick();
        total++; if (busy16 !== 1'b0 || done16 !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b want=00", busy16, done16); end
        total++; if (bus16.mem_rd !== 1'b0 || bus16.mab !== 16'h0) begin bad++; $display("FAIL rst_bus got rd=%b mab=%h want 0/0000", bus16.mem_rd, bus16.mab); end
        total++; if ({op_src16, op_dst16, dst_addr16, pc_out16} !== 64'h0 || src_inc16 !== 2'd0) begin bad++; $display("FAIL rst_outputs got=%h/%h/%h/%h/%0d want all 0", op_src16, op_dst16, dst_addr16, pc_out16, src_inc16); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_register();
        int cyc, rd;
        src_mode = 2'd0; dst_mode = 1'b0; dst_rd = 1'b0; bw = 1'b0; src_is_pc = 1'b0;
        r_src = 20'd40; r_dst = 20'd80; pc = 20'h1000;
        run_op(cyc, rd);
        total++; if (cyc !== 1) begin bad++; $display("FAIL reg_latency got=%0d want=1", cyc); end
        total++; if (op_src16 !== 16'd40 || op_dst16 !== 16'd80) begin bad++; $display("FAIL reg_ops got=%0d/%0d want=40/80", op_src16, op_dst16); end
        total++; if (rd !== 0) begin bad++; $display("FAIL reg_no_read got=%0d want=0", rd); end
        total++; if (pc_out16 !== 16'h1000 || src_inc16 !== 2'd0) begin bad++; $display("FAIL reg_pc_inc got=%h/%0d want=1000/0", pc_out16, src_inc16); end
        tick();
        total++; if (done16 !== 1'b0 || busy16 !== 1'b0) begin bad++; $display("FAIL reg_done_pulse got=%b%b want=00", done16, busy16); end
        total++; if (op_src16 !== 16'd40) begin bad++; $display("FAIL reg_hold got=%0d want=40", op_src16); end
    endtask

    task automatic test_indexed_src();
        int cyc, rd;
        wait_n = 0;
        src_mode = 2'd1; dst_mode = 1'b0; bw = 1'b0; src_is_pc = 1'b0;
        r_src = 20'h00200; r_dst = 20'h00055; pc = 20'h0C002;
        mem_wr(32'hC002, 16'h0010);
        mem_wr(32'h0210, 16'h1234);
        run_op(cyc, rd);
        total++; if (cyc !== 3) begin bad++; $display("FAIL idx_latency got=%0d want=3", cyc); end
        total++; if (op_src16 !== 16'h1234) begin bad++; $display("FAIL idx_op_src got=%h want=1234", op_src16); end
        total++; if (pc_out16 !== 16'hC004 || op_dst16 !== 16'h0055) begin bad++; $display("FAIL idx_pc_dst got=%h/%h want=c004/0055", pc_out16, op_dst16); end
        tick();
    endtask

    task automatic test_byte_autoinc();
        int cyc, rd;
        src_mode = 2'd3; dst_mode = 1'b0; bw = 1'b1; src_is_pc = 1'b0;
        r_src = 20'h00301; pc = 20'h02000;
        mem_wr(32'h0300, 16'hABCD);
        run_op(cyc, rd);
        total++; if (op_src16 !== 16'h00AB || src_inc16 !== 2'd1) begin bad++; $display("FAIL ainc_byte_odd got=%h/%0d want=00ab/1", op_src16, src_inc16); end
        total++; if (cyc !== 2 || pc_out16 !== 16'h2000) begin bad++; $display("FAIL ainc_lat_pc got=%0d/%h want=2/2000", cyc, pc_out16); end
        tick();
        r_src = 20'h00300;
        run_op(cyc, rd);
        total++; if (op_src16 !== 16'h00CD) begin bad++; $display("FAIL ainc_byte_even got=%h want=00cd", op_src16); end
        tick();
        bw = 1'b0;
        run_op(cyc, rd);
        total++; if (op_src16 !== 16'hABCD || src_inc16 !== 2'd2) begin bad++; $display("FAIL ainc_word got=%h/%0d want=abcd/2", op_src16, src_inc16); end
        tick();
    endtask

    task automatic test_imm_symbolic();
        int cyc, rd;
        src_mode = 2'd3; dst_mode = 1'b0; bw = 1'b0; src_is_pc = 1'b1;
        r_src = 20'h00500; pc = 20'h03000;
        mem_wr(32'h3000, 16'h7777);
        run_op(cyc, rd);
        total++; if (op_src16 !== 16'h7777 || cyc !== 2) begin bad++; $display("FAIL imm_op got=%h/%0d want=7777/2", op_src16, cyc); end
        total++; if (pc_out16 !== 16'h3002 || src_inc16 !== 2'd2) begin bad++; $display("FAIL imm_pc_inc got=%h/%0d want=3002/2", pc_out16, src_inc16); end
        tick();
        src_mode = 2'd1;
        mem_wr(32'h3000, 16'h0100);
        mem_wr(32'h3100, 16'h4242);
        run_op(cyc, rd);
        total++; if (op_src16 !== 16'h4242 || cyc !== 3) begin bad++; $display("FAIL sym_op got=%h/%0d want=4242/3", op_src16, cyc); end
        tick();
    endtask

    task automatic test_wait_dst();
        int cyc, unstable, n_ext, n_rd;
        logic [15:0] prev_mab;
        logic prev_wait;
        wait_n = 3;
        src_mode = 2'd0; dst_mode = 1'b1; dst_rd = 1'b1; bw = 1'b0; src_is_pc = 1'b0;
        r_src = 20'h00011; r_dst = 20'h00400; pc = 20'h04000;
        mem_wr(32'h4000, 16'h0006);
        mem_wr(32'h0406, 16'h9ABC);
        unstable = 0; n_ext = 0; n_rd = 0; prev_wait = 1'b0; prev_mab = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 200) begin
            if (prev_wait && (bus16.mem_rd !== 1'b1 || bus16.mab !== prev_mab)) unstable++;
            if (bus16.mem_rd && bus16.mab == 16'h4000) n_ext++;
            if (bus16.mem_rd && bus16.mab == 16'h0406) n_rd++;
            prev_wait = bus16.mem_rd && !bus16.mem_rdy;
            prev_mab = bus16.mab;
            tick();
            cyc++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL wait_stable got=%0d want=0", unstable); end
        total++; if (n_ext !== 4 || n_rd !== 4) begin bad++; $display("FAIL wait_cycles got=%0d/%0d want=4/4", n_ext, n_rd); end
        total++; if (cyc !== 9) begin bad++; $display("FAIL wait_latency got=%0d want=9", cyc); end
        total++; if (dst_addr16 !== 16'h0406 || op_dst16 !== 16'h9ABC) begin bad++; $display("FAIL wait_dst got=%h/%h want=0406/9abc", dst_addr16, op_dst16); end
        total++; if (pc_out16 !== 16'h4002) begin bad++; $display("FAIL wait_pc got=%h want=4002", pc_out16); end
        dst_mode = 1'b0; dst_rd = 1'b0; wait_n = 0;
        tick();
    endtask

    task automatic test_wrap();
        int cyc, rd;
        logic [19:0] mab20;
        logic [15:0] mab16;
        src_mode = 2'd1; dst_mode = 1'b0; bw = 1'b0; src_is_pc = 1'b0;
        r_src = 20'hFFFF0; pc = 20'h05000;
        mem_wr(32'h5000, 16'h0020);
        mem_wr(32'h00010, 16'h5A5A);
        mem_wr(32'h10010, 16'h0BAD);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mab16 = bus16.mab;
        mab20 = bus20.mab;
        tick();
        total++; if (mab16 !== 16'h0010 || mab20 !== 20'h00010) begin bad++; $display("FAIL wrap_mab got=%h/%h want=0010/00010", mab16, mab20); end
        total++; if (done16 !== 1'b1 || op_src16 !== 16'h5A5A || op_src20 !== 16'h5A5A) begin bad++; $display("FAIL wrap_op got=%b %h/%h want=1 5a5a/5a5a", done16, op_src16, op_src20); end
        total++; if (pc_out20 !== 20'h05002) begin bad++; $display("FAIL wrap_pc20 got=%h want=05002", pc_out20); end
        tick();
        r_src = 20'h0FFF0;
        run_op(cyc, rd);
        total++; if (op_src16 !== 16'h5A5A || op_src20 !== 16'h0BAD) begin bad++; $display("FAIL width_op got=%h/%h want=5a5a/0bad", op_src16, op_src20); end
        tick();
    endtask

    task automatic test_abort_busy();
        int cyc, rd, bad_mab;
        wait_n = 5;
        src_mode = 2'd2; dst_mode = 1'b0; bw = 1'b0; src_is_pc = 1'b0;
        r_src = 20'h00600; pc = 20'h06000;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (bus16.mem_rd !== 1'b1 || bus16.mab !== 16'h0600) begin bad++; $display("FAIL abort_pre got=%b/%h want=1/0600", bus16.mem_rd, bus16.mab); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus16.mem_rd !== 1'b0 || busy16 !== 1'b0 || bus16.mab !== 16'h0) begin bad++; $display("FAIL abort_async got rd=%b busy=%b mab=%h want 0/0/0000", bus16.mem_rd, busy16, bus16.mab); end
        total++; if ({op_src16, op_dst16, pc_out16} !== 48'h0 || done16 !== 1'b0) begin bad++; $display("FAIL abort_outs got=%h/%h/%h done=%b want 0", op_src16, op_dst16, pc_out16, done16); end
        tick();
        rst = 1'b1;
        tick();
        src_mode = 2'd0; bw = 1'b1; r_src = 20'h001F3; r_dst = 20'h00022; pc = 20'h07000;
        run_op(cyc, rd);
        total++; if (cyc !== 1 || op_src16 !== 16'h00F3 || op_dst16 !== 16'h0022) begin bad++; $display("FAIL post_rst_reg got=%0d %h/%h want=1 00f3/0022", cyc, op_src16, op_dst16); end
        tick();
        wait_n = 3; bw = 1'b0; src_mode = 2'd2; r_src = 20'h00700;
        mem_wr(32'h0700, 16'h1111);
        mem_wr(32'h0800, 16'h2222);
        start = 1'b1;
        tick();
        start = 1'b0;
        src_mode = 2'd0; r_src = 20'h00800;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 2;
        bad_mab = (bus16.mab !== 16'h0700) ? 1 : 0;
        while (!done16 && cyc < 200) begin
            if (bus16.mem_rd && bus16.mab !== 16'h0700) bad_mab++;
            tick();
            cyc++;
        end
        total++; if (op_src16 !== 16'h1111 || cyc !== 5) begin bad++; $display("FAIL busy_ignore got=%h/%0d want=1111/5", op_src16, cyc); end
        total++; if (bad_mab !== 0) begin bad++; $display("FAIL busy_mab got=%0d want=0", bad_mab); end
        tick();
        total++; if (busy16 !== 1'b0 || bus16.mem_rd !== 1'b0) begin bad++; $display("FAIL busy_no_restart got=%b/%b want=0/0", busy16, bus16.mem_rd); end
    endtask

    initial begin
        test_reset();
        test_register();
        test_indexed_src();
        test_byte_autoinc();
        test_imm_symbolic();
        test_wait_dst();
        test_wrap();
        test_abort_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_fetch_seq.md
Name: operand_fetch_seq

Overview:
Parametrised, multi-cycle operand fetch sequencer for the MSP430/MSP430X CPU core. Given decoded As/Ad addressing modes, register values and the current PC, it reads extension words and memory operands over a ready-handshaked memory port. It returns source/destination operands, the destination effective address, the updated PC and the autoincrement amount. Sits between the instruction decoder and the execute stage and supersedes the single-cycle combinational operand fetch.

Parameters:
ADDR_W, 16, address/PC width (20 for MSP430X); all address arithmetic is modulo 2^ADDR_W
DATA_W, 16, memory data bus and operand width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin fetch for a decoded instruction; ignored while busy=1
src_mode  in  2  As: 0 register, 1 indexed X(Rn), 2 indirect @Rn, 3 autoinc @Rn+
dst_mode  in  1  Ad: 0 register, 1 indexed X(Rn)
dst_rd  in  1  1 = read memory destination (0 for MOV-class)
bw  in  1  1 = byte operation
src_is_pc  in  1  source register is PC (As=3 gives immediate, As=1 gives symbolic)
r_src  in  ADDR_W  source register value
r_dst  in  ADDR_W  destination register value
pc  in  ADDR_W  address of the first extension word
mdb  in  DATA_W  memory read data
mem_rdy  in  1  memory access complete this cycle
mab  out  ADDR_W  memory address
mem_rd  out  1  memory read request
op_src  out  DATA_W  source operand
op_dst  out  DATA_W  destination operand
dst_addr  out  ADDR_W  destination effective address (valid when dst_mode=1)
pc_out  out  ADDR_W  PC after the extension words consumed
src_inc  out  2  increment for the source register: 0, 1 or 2
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: all outputs valid

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are 0: mab, mem_rd, op_src, op_dst, dst_addr, pc_out, src_inc, busy and done.
- States: IDLE, SRC_EXT, SRC_RD, DST_EXT, DST_RD, DONE.
- IDLE: on start, latch all inputs, set pc_cur=pc and busy=1, then go to the first needed state in the order SRC_EXT, SRC_RD, DST_EXT, DST_RD, DONE.
- SRC_EXT (src_mode=1, or src_mode=3 with src_is_pc): read at pc_cur, then pc_cur+=2.
  - Immediate: op_src=mdb and SRC_RD is skipped.
  - Indexed: ea=r_src+mdb. Symbolic uses the PC of this extension word as base.
- SRC_RD (src_mode 1/2/3 and not immediate): read at ea, or at r_src for modes 2/3.
- DST_EXT (dst_mode=1): read at pc_cur, dst_addr=r_dst+mdb, pc_cur+=2.
- DST_RD (dst_mode=1 and dst_rd=1): read at dst_addr into op_dst.
- Register modes: op_src=r_src and op_dst=r_dst, zero-extended or truncated to DATA_W. In byte mode only bits[7:0] are kept, zero-extended.
- Memory handshake: mem_rd=1 with mab stable from state entry until a cycle with mem_rdy=1. Data is captured on that edge and the state advances. No request is dropped or restarted.
- Word access: mab[0] is forced to 0. Byte operand read: the odd address selects mdb[15:8], the even address selects mdb[7:0]; the result is zero-extended. Extension-word fetches are always word accesses.
- DONE: done=1 for one cycle and pc_out=pc_cur. Then go to IDLE with busy=0.
- src_inc: 2 if src_mode=3 and (bw=0 or src_is_pc), 1 if src_mode=3 and bw=1, otherwise 0.
- Latency with mem_rdy tied high: all-register operation gives done 1 cycle after start; each memory access adds 1 cycle.
- Outputs hold their values after done until the next start.
- start while busy: ignored.
- Reset mid-sequence: aborts immediately and mem_rd drops asynchronously.

Test Plan:
- Register: src_mode=0, dst_mode=0, r_src=40, r_dst=80, start -> done at cycle +1, op_src=40, op_dst=80, mem_rd never 1, pc_out=pc, src_inc=0.
- Indexed src: r_src=0x0200, pc=0xC002, mem[0xC002]=0x0010, mem[0x0210]=0x1234, rdy high -> op_src=0x1234, pc_out=0xC004, done at cycle +3.
- Byte autoinc: src_mode=3, bw=1, r_src=0x0301, mem word at 0x0300=0xABCD -> op_src=0x00AB, src_inc=1. Repeat with bw=0 and r_src=0x0300 -> op_src=0xABCD, src_inc=2.
- Wait states plus indexed dst: dst_mode=1, dst_rd=1, r_dst=0x0400, ext word 0x0006, mem_rdy low 3 cycles per access -> mab and mem_rd stable while waiting, dst_addr=0x0406, op_dst=mem[0x0406].
- Wrap and width: ADDR_W=16, r_src=0xFFF0, X=0x0020 -> operand read at 0x0010. ADDR_W=20, r_src=0xFFFF0, X=0x0020 -> read at 0x00010.
- Reset/abort: rst=0 during SRC_RD -> all outputs 0 immediately, busy=0. After release, a start with a register-mode instruction completes normally; a start pulsed while busy has no effect.
